// File: rtl/mips_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mips_mc_ctrl
// Brief    : Multi-cycle MIPS controller. Sequences fetch, decode, execute,
//            memory and writeback over one shared memory port, with a
//            wait-state timeout, an illegal-opcode trap and a retired count.
// Revision : 1.0 - initial release
// ============================================================================
module mips_mc_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5,
    parameter int PERF_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        opcode,
    input  logic [5:0]        funct,
    input  logic [31:0]       NFlag,
    input  logic              mem_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic              ir_wr,
    output logic              pc_wr,
    output logic              RegWr,
    output logic              ALUSrc,
    output logic [1:0]        RegDst,
    output logic [1:0]        Mem2Reg,
    output logic [1:0]        NPCSel,
    output logic [1:0]        EXTOp,
    output logic [2:0]        ALUOp,
    output logic [3:0]        state,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [PERF_W-1:0] retired
);

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_JAL   = 6'h03;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_ORI   = 6'h0d;
    localparam logic [5:0] c_OP_LUI   = 6'h0f;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2b;
    localparam logic [5:0] c_FN_JR    = 6'h08;
    localparam logic [5:0] c_FN_ADDU  = 6'h21;
    localparam logic [5:0] c_FN_SUBU  = 6'h23;
    localparam logic [5:0] c_FN_SLT   = 6'h2a;

    localparam logic       c_ALUSRC_B    = 1'b0;
    localparam logic       c_ALUSRC_EXT  = 1'b1;
    localparam logic [1:0] c_REGDST_RT   = 2'd0;
    localparam logic [1:0] c_REGDST_RD   = 2'd1;
    localparam logic [1:0] c_REGDST_RET  = 2'd2;
    localparam logic [1:0] c_MEM2REG_ALU = 2'd0;
    localparam logic [1:0] c_MEM2REG_RAM = 2'd1;
    localparam logic [1:0] c_MEM2REG_RET = 2'd2;
    localparam logic [1:0] c_NPC_PC4     = 2'd0;
    localparam logic [1:0] c_NPC_BRANCH  = 2'd1;
    localparam logic [1:0] c_NPC_JUMP    = 2'd2;
    localparam logic [1:0] c_NPC_REG     = 2'd3;
    localparam logic [1:0] c_EXT_ZERO    = 2'd0;
    localparam logic [1:0] c_EXT_SIGN    = 2'd1;
    localparam logic [1:0] c_EXT_UPPER   = 2'd2;
    localparam logic [2:0] c_ALU_ADD     = 3'd0;
    localparam logic [2:0] c_ALU_SUB     = 3'd1;
    localparam logic [2:0] c_ALU_OR      = 3'd2;
    localparam logic [2:0] c_ALU_SLT     = 3'd3;
    localparam logic [1:0] c_ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] c_ERR_TIMEOUT = 2'b10;

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXE    = 4'd2,
        S_MEM    = 4'd3,
        S_WB_ALU = 4'd4,
        S_WB_MEM = 4'd5,
        S_BRANCH = 4'd6,
        S_JUMP   = 4'd7,
        S_TRAP   = 4'd8
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [PERF_W-1:0]   r_retired;
    logic                r_err;
    logic [1:0]          r_err_code;
    logic                w_wait;
    logic                w_retire;
    logic [1:0]          w_trap_code;

    logic w_rtype, w_addu, w_subu, w_slt, w_jr;
    logic w_ori, w_lui, w_lw, w_sw, w_beq, w_j, w_jal;
    logic w_alu_instr;
    logic       w_alusrc;
    logic [1:0] w_extop;
    logic [2:0] w_aluop;
    logic       unused_nflag;

    assign w_rtype     = (opcode == c_OP_RTYPE);
    assign w_addu      = w_rtype && (funct == c_FN_ADDU);
    assign w_subu      = w_rtype && (funct == c_FN_SUBU);
    assign w_slt       = w_rtype && (funct == c_FN_SLT);
    assign w_jr        = w_rtype && (funct == c_FN_JR);
    assign w_ori       = (opcode == c_OP_ORI);
    assign w_lui       = (opcode == c_OP_LUI);
    assign w_lw        = (opcode == c_OP_LW);
    assign w_sw        = (opcode == c_OP_SW);
    assign w_beq       = (opcode == c_OP_BEQ);
    assign w_j         = (opcode == c_OP_J);
    assign w_jal       = (opcode == c_OP_JAL);
    assign w_alu_instr = w_addu || w_subu || w_slt || w_ori || w_lui;

    // Datapath selects held steady from EXE through writeback of the instruction.
    assign w_alusrc = (w_ori || w_lui || w_lw || w_sw) ? c_ALUSRC_EXT : c_ALUSRC_B;
    assign w_extop  = w_ori ? c_EXT_ZERO : (w_lui ? c_EXT_UPPER : c_EXT_SIGN);
    assign w_aluop  = w_subu ? c_ALU_SUB : (w_slt ? c_ALU_SLT : (w_ori ? c_ALU_OR : c_ALU_ADD));

    // Only the zero flag steers branches; the rest of the flag word is not needed here.
    assign unused_nflag = ^NFlag[31:1];

    always_comb begin
        w_next      = r_state;
        w_wait      = 1'b0;
        w_retire    = 1'b0;
        w_trap_code = 2'b00;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        ir_wr       = 1'b0;
        pc_wr       = 1'b0;
        RegWr       = 1'b0;
        ALUSrc      = c_ALUSRC_B;
        RegDst      = c_REGDST_RT;
        Mem2Reg     = c_MEM2REG_ALU;
        NPCSel      = c_NPC_PC4;
        EXTOp       = c_EXT_ZERO;
        ALUOp       = c_ALU_ADD;

        case (r_state)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_wr  = 1'b1;
                    pc_wr  = 1'b1;
                    w_next = S_DECODE;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_next      = S_TRAP;
                    w_trap_code = c_ERR_TIMEOUT;
                end else begin
                    w_wait = 1'b1;
                end
            end
            S_DECODE: begin
                if (w_alu_instr || w_lw || w_sw) begin
                    w_next = S_EXE;
                end else if (w_beq) begin
                    w_next = S_BRANCH;
                end else if (w_j || w_jal || w_jr) begin
                    w_next = S_JUMP;
                end else begin
                    w_next      = S_TRAP;
                    w_trap_code = c_ERR_ILLEGAL;
                end
            end
            S_EXE: begin
                ALUSrc = w_alusrc;
                EXTOp  = w_extop;
                ALUOp  = w_aluop;
                w_next = (w_lw || w_sw) ? S_MEM : S_WB_ALU;
            end
            S_MEM: begin
                ALUSrc  = w_alusrc;
                EXTOp   = w_extop;
                ALUOp   = w_aluop;
                mem_req = 1'b1;
                mem_we  = w_sw;
                if (mem_ready) begin
                    w_next   = w_sw ? S_FETCH : S_WB_MEM;
                    w_retire = w_sw;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_next      = S_TRAP;
                    w_trap_code = c_ERR_TIMEOUT;
                end else begin
                    w_wait = 1'b1;
                end
            end
            S_WB_ALU: begin
                ALUSrc   = w_alusrc;
                EXTOp    = w_extop;
                ALUOp    = w_aluop;
                RegWr    = 1'b1;
                Mem2Reg  = c_MEM2REG_ALU;
                RegDst   = w_rtype ? c_REGDST_RD : c_REGDST_RT;
                w_retire = 1'b1;
                w_next   = S_FETCH;
            end
            S_WB_MEM: begin
                ALUSrc   = w_alusrc;
                EXTOp    = w_extop;
                RegWr    = 1'b1;
                Mem2Reg  = c_MEM2REG_RAM;
                RegDst   = c_REGDST_RT;
                w_retire = 1'b1;
                w_next   = S_FETCH;
            end
            S_BRANCH: begin
                ALUOp    = c_ALU_SUB;
                EXTOp    = c_EXT_SIGN;
                NPCSel   = c_NPC_BRANCH;
                pc_wr    = NFlag[0];
                w_retire = 1'b1;
                w_next   = S_FETCH;
            end
            S_JUMP: begin
                pc_wr  = 1'b1;
                NPCSel = w_jr ? c_NPC_REG : c_NPC_JUMP;
                if (w_jal) begin
                    RegWr   = 1'b1;
                    RegDst  = c_REGDST_RET;
                    Mem2Reg = c_MEM2REG_RET;
                end
                w_retire = 1'b1;
                w_next   = S_FETCH;
            end
            S_TRAP: begin
                w_next = S_TRAP;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase

        // Nothing may reach the datapath or memory while reset is asserted.
        if (rst) begin
            mem_req = 1'b0;
            mem_we  = 1'b0;
            ir_wr   = 1'b0;
            pc_wr   = 1'b0;
            RegWr   = 1'b0;
            ALUSrc  = c_ALUSRC_B;
            RegDst  = c_REGDST_RT;
            Mem2Reg = c_MEM2REG_ALU;
            NPCSel  = c_NPC_PC4;
            EXTOp   = c_EXT_ZERO;
            ALUOp   = c_ALU_ADD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_FETCH;
            r_cnt      <= '0;
            r_retired  <= '0;
            r_err      <= 1'b0;
            r_err_code <= 2'b00;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_wait ? (r_cnt + 1'b1) : '0;
            if (w_retire) begin
                r_retired <= r_retired + 1'b1;
            end
            if ((w_trap_code != 2'b00) && !r_err) begin
                r_err      <= 1'b1;
                r_err_code <= w_trap_code;
            end
        end
    end

    assign state    = r_state;
    assign err      = r_err;
    assign err_code = r_err_code;
    assign retired  = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_mips_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_mc_ctrl
// Brief    : Self-checking bench for mips_mc_ctrl: directed cases plus a
//            randomized instruction stream against an instruction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_mc_ctrl;

    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 5;
    localparam int PERF_W  = 32;
    localparam int NEVER   = 1000;

    localparam logic [1:0] RD_RT = 2'd0, RD_RD = 2'd1, RD_RET = 2'd2;
    localparam logic [1:0] M2R_ALU = 2'd0, M2R_RAM = 2'd1, M2R_RET = 2'd2;
    localparam logic [1:0] NPC_PC4 = 2'd0, NPC_BR = 2'd1, NPC_J = 2'd2, NPC_JR = 2'd3;

    localparam int K_ADDU = 0, K_SUBU = 1, K_SLT = 2, K_ORI = 3, K_LUI = 4, K_LW = 5;
    localparam int K_SW = 6, K_BEQ = 7, K_J = 8, K_JAL = 9, K_JR = 10, K_ILL = 11, K_ILLR = 12;

    logic              clk = 1'b0;
    logic              rst;
    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic [31:0]       NFlag;
    logic              mem_ready;
    logic              mem_req, mem_we, ir_wr, pc_wr, RegWr, ALUSrc;
    logic [1:0]        RegDst, Mem2Reg, NPCSel, EXTOp;
    logic [2:0]        ALUOp;
    logic [3:0]        state;
    logic              err;
    logic [1:0]        err_code;
    logic [PERF_W-1:0] retired;

    int total = 0;
    int bad   = 0;

    mips_mc_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W), .PERF_W(PERF_W)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .NFlag(NFlag),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .ir_wr(ir_wr),
        .pc_wr(pc_wr), .RegWr(RegWr), .ALUSrc(ALUSrc), .RegDst(RegDst),
        .Mem2Reg(Mem2Reg), .NPCSel(NPCSel), .EXTOp(EXTOp), .ALUOp(ALUOp),
        .state(state), .err(err), .err_code(err_code), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] encode(input int kind);
        case (kind)
            K_ADDU:  return {6'h00, 6'h21};
            K_SUBU:  return {6'h00, 6'h23};
            K_SLT:   return {6'h00, 6'h2a};
            K_ORI:   return {6'h0d, 6'h15};
            K_LUI:   return {6'h0f, 6'h3c};
            K_LW:    return {6'h23, 6'h04};
            K_SW:    return {6'h2b, 6'h08};
            K_BEQ:   return {6'h04, 6'h10};
            K_J:     return {6'h02, 6'h01};
            K_JAL:   return {6'h03, 6'h22};
            K_JR:    return {6'h00, 6'h08};
            K_ILLR:  return {6'h00, 6'h00};
            default: return {6'h3f, 6'h00};
        endcase
    endfunction

    // Runs one instruction from FETCH to its retirement (or trap), observing per-cycle
    // outputs, and compares the tallies against the instruction-level expectation.
    task automatic run_instr(input string tag, input int kind, input int fw, input int mw, input bit nf);
        int cyc = 0, k = 0, phase = 0;
        int n_req = 0, n_we = 0, n_ir = 0, n_pc = 0, n_rw = 0, n_fpc = 0, n_pair = 0;
        int e_cyc, e_req, e_we, e_pc, e_rw;
        logic [1:0] rd_seen = 2'd0, m2r_seen = 2'd0, npc_last = 2'd0;
        logic [1:0] e_rd = 2'd0, e_m2r = 2'd0, e_code = 2'b00;
        logic [PERF_W-1:0] ret0 = retired;
        logic [PERF_W-1:0] pre;
        bit done = 1'b0;
        bit trap = 1'b0;
        bit fetched = (fw != NEVER);
        bit is_jump = (kind == K_J) || (kind == K_JAL) || (kind == K_JR) || (kind == K_BEQ);
        logic [11:0] enc = encode(kind);

        opcode = enc[11:6];
        funct  = enc[5:0];
        NFlag  = {$urandom(), 1'b0} | 32'(nf);
        NFlag[0] = nf;

        e_req = fw + 1; e_we = 0; e_pc = 1; e_rw = 0;
        case (kind)
            K_ADDU, K_SUBU, K_SLT: begin e_cyc = 4 + fw; e_rw = 1; e_rd = RD_RD; e_m2r = M2R_ALU; end
            K_ORI, K_LUI:          begin e_cyc = 4 + fw; e_rw = 1; e_rd = RD_RT; e_m2r = M2R_ALU; end
            K_LW:  begin e_cyc = 5 + fw + mw; e_req = fw + mw + 2; e_rw = 1; e_rd = RD_RT; e_m2r = M2R_RAM; end
            K_SW:  begin e_cyc = 4 + fw + mw; e_req = fw + mw + 2; e_we = mw + 1; end
            K_BEQ: begin e_cyc = 3 + fw; e_pc = 1 + int'(nf); end
            K_J, K_JR: begin e_cyc = 3 + fw; e_pc = 2; end
            K_JAL: begin e_cyc = 3 + fw; e_pc = 2; e_rw = 1; e_rd = RD_RET; e_m2r = M2R_RET; end
            default: begin e_cyc = 2 + fw; trap = 1'b1; e_code = 2'b01; end
        endcase
        if (!fetched) begin
            e_cyc = TIMEOUT; e_req = TIMEOUT; e_pc = 0; e_rw = 0; trap = 1'b1; e_code = 2'b10;
        end

        while (!done && cyc < 100) begin
            @(negedge clk);
            if (mem_req) mem_ready = (k >= ((phase == 0) ? fw : mw));
            else         mem_ready = 1'($urandom_range(0, 1));
            #1;
            if (mem_req) n_req++;
            if (mem_we)  n_we++;
            if (ir_wr)   n_ir++;
            if (pc_wr)   n_pc++;
            if (ir_wr && pc_wr && NPCSel == NPC_PC4) n_fpc++;
            if (pc_wr && RegWr) n_pair++;
            if (RegWr) begin n_rw++; rd_seen = RegDst; m2r_seen = Mem2Reg; end
            npc_last = NPCSel;
            if (mem_req) begin
                if (mem_ready) begin k = 0; phase++; end
                else k++;
            end
            cyc++;
            pre = retired;
            @(posedge clk); #1;
            if (retired !== pre || err) done = 1'b1;
        end

        check({tag, ".finished"}, 64'(done), 64'd1);
        check({tag, ".cycles"},   64'(cyc), 64'(e_cyc));
        check({tag, ".mem_req"},  64'(n_req), 64'(e_req));
        check({tag, ".mem_we"},   64'(n_we), 64'(e_we));
        check({tag, ".ir_wr"},    64'(n_ir), 64'(fetched ? 1 : 0));
        check({tag, ".fetch_pc"}, 64'(n_fpc), 64'(fetched ? 1 : 0));
        check({tag, ".pc_wr"},    64'(n_pc), 64'(e_pc));
        check({tag, ".RegWr"},    64'(n_rw), 64'(e_rw));
        if (e_rw != 0) begin
            check({tag, ".RegDst"},  64'(rd_seen), 64'(e_rd));
            check({tag, ".Mem2Reg"}, 64'(m2r_seen), 64'(e_m2r));
        end
        if (is_jump && !trap) begin
            check({tag, ".NPCSel"}, 64'(npc_last),
                  64'((kind == K_BEQ) ? NPC_BR : ((kind == K_JR) ? NPC_JR : NPC_J)));
        end
        if (kind == K_JAL) check({tag, ".jal_same_cycle"}, 64'(n_pair), 64'd1);
        check({tag, ".retired"},  64'(retired), 64'(trap ? ret0 : ret0 + 1'b1));
        check({tag, ".err"},      64'(err), 64'(trap));
        check({tag, ".err_code"}, 64'(err_code), 64'(e_code));
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        mem_ready = 1'b1;
        #1;
        check({tag, ".rst_enables"}, 64'({mem_req, mem_we, ir_wr, pc_wr, RegWr}), 64'd0);
        check({tag, ".rst_selects"}, 64'({ALUSrc, RegDst, Mem2Reg, NPCSel, EXTOp, ALUOp}), 64'd0);
        @(posedge clk); #1;
        check({tag, ".rst_retired"}, 64'(retired), 64'd0);
        check({tag, ".rst_err"},     64'({err, err_code}), 64'd0);
        rst = 1'b0;
        mem_ready = 1'b0;
    endtask

    initial begin
        logic [PERF_W-1:0] ret_hold;
        rst = 1'b1; opcode = 6'h00; funct = 6'h00; NFlag = 32'd0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        do_reset("reset");

        run_instr("addu", K_ADDU, 0, 0, 1'b0);
        run_instr("lw_wait3", K_LW, 0, 3, 1'b0);
        run_instr("beq_nt", K_BEQ, 0, 0, 1'b0);
        run_instr("beq_t", K_BEQ, 0, 0, 1'b1);
        run_instr("jal", K_JAL, 0, 0, 1'b0);
        run_instr("sw_wait2", K_SW, 1, 2, 1'b0);
        run_instr("ori_edge", K_ORI, TIMEOUT - 1, 0, 1'b0);
        run_instr("lw_edge", K_LW, 0, TIMEOUT - 1, 1'b0);

        for (int i = 0; i < 30; i++) begin
            run_instr("rand", int'($urandom_range(0, 10)), int'($urandom_range(0, 4)),
                      int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
        end

        // Reset while WB_ALU would be writing: no write may escape.
        do_reset("mid");
        opcode = 6'h00; funct = 6'h21;
        repeat (3) begin
            @(negedge clk); mem_ready = 1'b1;
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid.no_write", 64'({RegWr, pc_wr, mem_req, ir_wr}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid.retired", 64'(retired), 64'd0);
        run_instr("mid.addu", K_ADDU, 0, 0, 1'b0);

        run_instr("illegal", K_ILL, 2, 0, 1'b0);
        ret_hold = retired;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            mem_ready = 1'($urandom_range(0, 1));
            #1;
            check("trap.enables", 64'({mem_req, mem_we, ir_wr, pc_wr, RegWr}), 64'd0);
            check("trap.sticky", 64'({err, err_code}), 64'({1'b1, 2'b01}));
            check("trap.retired", 64'(retired), 64'(ret_hold));
        end

        do_reset("after_ill");
        run_instr("illegal_r", K_ILLR, 0, 0, 1'b0);

        do_reset("pre_tmo");
        run_instr("timeout", K_ADDU, NEVER, 0, 1'b0);
        do_reset("after_tmo");
        run_instr("post_tmo", K_JR, 0, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
